write_scoreboard: RTL
=====================

WRITE_SCOREBOARD -- requirements
Module: write_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter NUM_EXP, default 4, expected-write table depth (1..16).
REQ-004 SHALL have parameter TIMEOUT, default 100, RUN cycles before timeout failure (>=1).
REQ-005 SHALL have parameter BENIGN_ADDR, default 80, address whose writes are ignored.
REQ-006 SHALL have parameter ORDERED, default 1: 1 = expected writes must match in index order; 0 = any order.
REQ-007 pin_clock  in  1  sole clock; all state updates on rising edge.
REQ-008 pin_n_reset  in  1  asynchronous, active-low reset.
REQ-009 write_enab  in  1  observed bus write strobe.
REQ-010 data_addr  in  ADDR_W  observed write address.
REQ-011 write_data  in  DATA_W  observed write data.
REQ-012 cfg_we  in  1  table-entry write strobe.
REQ-013 cfg_idx  in  clog2(NUM_EXP)  table index.
REQ-014 cfg_addr / cfg_data  in  ADDR_W / DATA_W  expected entry.
REQ-015 start  in  1  one-cycle pulse: clear progress, enter RUN.
REQ-016 done  out  1  high in PASS or FAIL.
REQ-017 pass  out  1  high in PASS only.
REQ-018 fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout.
REQ-019 match_count  out  clog2(NUM_EXP+1)  entries matched so far.

Function
REQ-020 FSM states IDLE, RUN, PASS, FAIL; outputs registered (Moore).
REQ-021 IDLE: cfg_we writes entry cfg_idx and sets its valid bit; start -> RUN.
REQ-022 cfg_we SHALL be ignored outside IDLE; cfg_idx >= NUM_EXP ignored.
REQ-023 start in RUN/PASS/FAIL SHALL clear matched bits, match_count, cycle counter, fail_code and enter RUN next cycle; table contents retained.
REQ-024 RUN, write_enab low: cycle counter increments; no other change.
REQ-025 RUN, write_enab with data_addr == BENIGN_ADDR: ignored (counter still increments).
REQ-026 ORDERED=1: candidate is entry match_count only; addr and data equal -> mark matched, match_count+1; addr equal, data differ -> FAIL code 2; addr differs -> FAIL code 1.
REQ-027 ORDERED=0: candidate is lowest-index valid, unmatched entry with equal addr; data equal -> match; data differ -> FAIL code 2; no candidate (incl. already-matched addr) -> FAIL code 1.
REQ-028 match_count reaching count of valid entries -> PASS on the next edge.
REQ-029 Zero valid entries: start -> RUN, then PASS next cycle.
REQ-030 Cycle counter reaching TIMEOUT in RUN -> FAIL code 3.
REQ-031 Same-cycle final match and timeout: PASS wins.
REQ-032 PASS/FAIL hold until start or reset; write_enab ignored.
REQ-033 Evaluation latency: done/pass/fail_code valid one edge after the deciding write.
REQ-034 Counter saturates at TIMEOUT; no wrap.

Reset
REQ-035 pin_n_reset low SHALL asynchronously force IDLE, clear table valid and matched bits, counters, done=0, pass=0, fail_code=0, match_count=0.
REQ-036 Reset mid-RUN SHALL abort without reporting; deassertion is synchronised to pin_clock by the surrounding logic.

Structure
REQ-037 Package wsb_pkg SHALL hold the state enum and fail-code enum/constants.
REQ-038 Sub-module wsb_expect_table SHALL hold entries, valid and matched bits, and the ORDERED/unordered candidate lookup; top holds FSM and counters.

Verification
REQ-039 ORDERED, entries {0:(84,7)}; writes (80,3),(84,7) -> pass=1, match_count=1, fail_code=0.
REQ-040 ORDERED, entries {(84,7),(88,9)}; writes (88,9) -> FAIL, fail_code=1, match_count=0.
REQ-041 ORDERED=0, same entries; writes (88,9),(84,7) -> PASS; repeat (88,9) before last match -> fail_code=1.
REQ-042 Entry (84,7); write (84,6) -> fail_code=2; then start, write (84,7) -> PASS.
REQ-043 TIMEOUT=10, no writes -> fail_code=3 after 10 RUN cycles; final match on cycle 10 -> PASS.
REQ-044 pin_n_reset low mid-RUN after one match -> immediate IDLE, all outputs 0, table invalid.

Source files
------------

// File: rtl/wsb_pkg.sv
// -----------------------------------------------------------------------------
// wsb_pkg -- shared types for the write scoreboard.
//   state_e      : scoreboard FSM states (IDLE, RUN, PASS, FAIL)
//   fail_code_e  : reported failure reason, 2 bits wide
//   idx_width    : width of a table index (never below 1 bit)
//   count_width  : width of a counter able to hold 0..n inclusive
// -----------------------------------------------------------------------------
package wsb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE          = 2'd0,
        FC_UNEXP_ADDR    = 2'd1,
        FC_DATA_MISMATCH = 2'd2,
        FC_TIMEOUT       = 2'd3
    } fail_code_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/wsb_expect_table.sv
// -----------------------------------------------------------------------------
// wsb_expect_table -- expected-write table with valid/matched bits and the
// candidate lookup used by the scoreboard FSM.
//   pin_clock, pin_n_reset : clock, async active-low reset
//   i_cfg_we/idx/addr/data : entry write (already gated to IDLE by the top)
//   i_clear_matched        : clear all matched bits (new run)
//   i_mark                 : mark the current candidate as matched
//   i_match_count          : entries matched so far (ordered candidate index)
//   i_addr, i_data         : observed write being evaluated
//   o_cand_found           : a candidate entry with equal address exists
//   o_cand_data_ok         : candidate's expected data equals i_data
//   o_num_valid            : number of valid entries
// -----------------------------------------------------------------------------
module wsb_expect_table
    import wsb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int NUM_EXP = 4,
    parameter  int ORDERED = 1,
    localparam int IW      = idx_width(NUM_EXP),
    localparam int MW      = count_width(NUM_EXP)
) (
    input  logic              pin_clock,
    input  logic              pin_n_reset,
    input  logic              i_cfg_we,
    input  logic [IW-1:0]     i_cfg_idx,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [DATA_W-1:0] i_cfg_data,
    input  logic              i_clear_matched,
    input  logic              i_mark,
    input  logic [MW-1:0]     i_match_count,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_cand_found,
    output logic              o_cand_data_ok,
    output logic [MW-1:0]     o_num_valid
);

    logic [ADDR_W-1:0]  r_addr [NUM_EXP];
    logic [DATA_W-1:0]  r_data [NUM_EXP];
    logic [NUM_EXP-1:0] r_valid;
    logic [NUM_EXP-1:0] r_matched;

    logic          w_found;
    logic [IW-1:0] w_cand_idx;
    logic [MW-1:0] w_num_valid;

    // NOTE: the entry payload is deliberately left without a reset; the valid
    // bits qualify it, so only those (and matched) need the reset network.
    always_ff @(posedge pin_clock) begin
        for (int i = 0; i < NUM_EXP; i++) begin
            if (i_cfg_we && int'(i_cfg_idx) == i) begin
                r_addr[i] <= i_cfg_addr;
                r_data[i] <= i_cfg_data;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge pin_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            r_valid   <= '0;
            r_matched <= '0;
        end else begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (i_cfg_we && int'(i_cfg_idx) == i) begin
                    r_valid[i] <= 1'b1;
                end
                if (i_clear_matched) begin
                    r_matched[i] <= 1'b0;
                end else if (i_mark && int'(w_cand_idx) == i) begin
                    r_matched[i] <= 1'b1;
                end
            end
        end
    end

    // Ordered: only the entry at index match_count may match.
    // Unordered: the lowest-index valid, unmatched entry with equal address;
    // scanning downwards lets the lowest hit overwrite higher ones.
    // NOTE: defaults are assigned first so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_found    = 1'b0;
        w_cand_idx = '0;
        if (ORDERED != 0) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (int'(i_match_count) == i && r_valid[i] && r_addr[i] == i_addr) begin
                    w_found    = 1'b1;
                    w_cand_idx = IW'(i);
                end
            end
        end else begin
            for (int i = NUM_EXP - 1; i >= 0; i--) begin
                if (r_valid[i] && !r_matched[i] && r_addr[i] == i_addr) begin
                    w_found    = 1'b1;
                    w_cand_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        w_num_valid = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            w_num_valid = w_num_valid + MW'(r_valid[i]);
        end
    end

    assign o_cand_found   = w_found;
    assign o_cand_data_ok = (r_data[w_cand_idx] == i_data);
    assign o_num_valid    = w_num_valid;

endmodule

// File: rtl/write_scoreboard.sv
// -----------------------------------------------------------------------------
// write_scoreboard -- watches bus writes and checks them against a table of
// expected (address, data) pairs, reporting PASS or a failure reason.
//   pin_clock, pin_n_reset         : clock, async active-low reset
//   write_enab/data_addr/write_data: observed bus write
//   cfg_we/cfg_idx/cfg_addr/cfg_data: expected-entry load (IDLE only)
//   start                          : one-cycle pulse, (re)start a run
//   done, pass                     : result flags (registered)
//   fail_code                      : 0 none, 1 unexpected addr, 2 data, 3 timeout
//   match_count                    : entries matched in the current run
// -----------------------------------------------------------------------------
module write_scoreboard
    import wsb_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int NUM_EXP     = 4,
    parameter  int TIMEOUT     = 100,
    parameter  int BENIGN_ADDR = 80,
    parameter  int ORDERED     = 1,
    localparam int IW          = idx_width(NUM_EXP),
    localparam int MW          = count_width(NUM_EXP),
    localparam int CW          = count_width(TIMEOUT)
) (
    input  logic              pin_clock,
    input  logic              pin_n_reset,
    input  logic              write_enab,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [MW-1:0]     match_count
);

    state_e     r_state,       w_next_state;
    fail_code_e r_fail_code,   w_next_code;
    logic [MW-1:0] r_match_count, w_next_mc;
    logic [CW-1:0] r_cycle_cnt,   w_next_cnt;
    logic          r_done, r_pass;

    logic          w_cfg_we;
    logic          w_clear;
    logic          w_mark;
    logic          w_benign;
    logic          w_found;
    logic          w_data_ok;
    logic [MW-1:0] w_num_valid;

    assign w_cfg_we = cfg_we && (r_state == ST_IDLE) && (int'(cfg_idx) < NUM_EXP);
    assign w_benign = (data_addr == ADDR_W'(BENIGN_ADDR));

    wsb_expect_table #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_EXP (NUM_EXP),
        .ORDERED (ORDERED)
    ) u_table (
        .pin_clock       (pin_clock),
        .pin_n_reset     (pin_n_reset),
        .i_cfg_we        (w_cfg_we),
        .i_cfg_idx       (cfg_idx),
        .i_cfg_addr      (cfg_addr),
        .i_cfg_data      (cfg_data),
        .i_clear_matched (w_clear),
        .i_mark          (w_mark),
        .i_match_count   (r_match_count),
        .i_addr          (data_addr),
        .i_data          (write_data),
        .o_cand_found    (w_found),
        .o_cand_data_ok  (w_data_ok),
        .o_num_valid     (w_num_valid)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fail_code;
        w_next_mc    = r_match_count;
        w_next_cnt   = r_cycle_cnt;
        w_clear      = 1'b0;
        w_mark       = 1'b0;

        if (start) begin
            // Restart from any state: progress cleared, table kept.
            w_next_state = ST_RUN;
            w_next_code  = FC_NONE;
            w_next_mc    = '0;
            w_next_cnt   = '0;
            w_clear      = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (r_cycle_cnt != CW'(TIMEOUT)) begin
                w_next_cnt = r_cycle_cnt + CW'(1);
            end

            if (r_match_count == w_num_valid) begin
                // Only reachable with an empty table; the last match of a
                // non-empty table moves to PASS directly below.
                w_next_state = ST_PASS;
            end else if (write_enab && !w_benign) begin
                if (w_found && w_data_ok) begin
                    w_mark    = 1'b1;
                    w_next_mc = r_match_count + MW'(1);
                    if (w_next_mc == w_num_valid) begin
                        w_next_state = ST_PASS;
                    end
                end else if (w_found) begin
                    w_next_state = ST_FAIL;
                    w_next_code  = FC_DATA_MISMATCH;
                end else begin
                    w_next_state = ST_FAIL;
                    w_next_code  = FC_UNEXP_ADDR;
                end
            end

            // Timeout only fires if this cycle's write did not already decide.
            if (w_next_state == ST_RUN && w_next_cnt == CW'(TIMEOUT)) begin
                w_next_state = ST_FAIL;
                w_next_code  = FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge pin_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            r_state       <= ST_IDLE;
            r_fail_code   <= FC_NONE;
            r_match_count <= '0;
            r_cycle_cnt   <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_fail_code   <= w_next_code;
            r_match_count <= w_next_mc;
            r_cycle_cnt   <= w_next_cnt;
            r_done        <= (w_next_state == ST_PASS) || (w_next_state == ST_FAIL);
            r_pass        <= (w_next_state == ST_PASS);
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign match_count = r_match_count;

endmodule
